// File: rtl/laser_pkg.sv
// ---------------------------------------------------------------------------
// laser_pkg
// Shared types and default constants for the laser burst controller.
//   laser_state_t : burst FSM state encoding (IDLE, ON, OFF, COOL)
//   LASER_*       : default timing/shape constants used as parameter defaults
//   laser_max3    : helper that sizes the shared phase counter
// ---------------------------------------------------------------------------
package laser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        COOL = 2'd3
    } laser_state_t;

    localparam int LASER_ON_LEN   = 16;
    localparam int LASER_OFF_LEN  = 8;
    localparam int LASER_PULSES   = 3;
    localparam int LASER_COOLDOWN = 32;

    // Largest of three phase lengths; one counter serves all timed phases.
    function automatic int laser_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/laser_req_arbiter.sv
// ---------------------------------------------------------------------------
// laser_req_arbiter
// Captures button requests, holds pending bits for the non-owner while a
// burst runs, and picks a winner whenever the controller opens arbitration.
// Build option: LASER_ROUND_ROBIN_EN selects round-robin on contention;
// without it requester 0 has fixed priority.
// Ports:
//   CLK, Reset  : clock, synchronous active-high reset
//   B0, B1      : conditioned button requests
//   arb_en      : high on edges where a new burst may be granted
//   owner       : one-hot owner of the running burst (00 when idle)
//   grant_valid : a winner exists on this arbitration edge
//   winner      : one-hot winner (meaningful only with grant_valid)
// ---------------------------------------------------------------------------
module laser_req_arbiter
    import laser_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic       B0,
    input  logic       B1,
    input  logic       arb_en,
    input  logic [1:0] owner,
    output logic       grant_valid,
    output logic [1:0] winner
);

    logic pend0;
    logic pend1;
    logic live0;
    logic live1;
    logic prefer1;

    assign live0       = B0 | pend0;
    assign live1       = B1 | pend1;
    assign grant_valid = arb_en & (live0 | live1);

`ifdef LASER_ROUND_ROBIN_EN
    // Index of the requester that won the most recent contested arbitration.
    // A loser's follow-up grant (served from its pending bit) completes the
    // same round and does not move the pointer, so contested rounds alternate.
    logic last_grant;

    assign prefer1 = ~last_grant;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            last_grant <= 1'b1;
        end else if (grant_valid && live0 && live1) begin
            last_grant <= winner[1];
        end
    end
`else
    assign prefer1 = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        winner = 2'b00;
        if (live0 && (!live1 || !prefer1)) begin
            winner = 2'b01;
        end else if (live1) begin
            winner = 2'b10;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else if (arb_en) begin
            // Winner's request is consumed; a losing live request is kept.
            if (grant_valid) begin
                pend0 <= live0 & ~winner[0];
                pend1 <= live1 & ~winner[1];
            end
        end else begin
            // Burst running: the owner's repeat presses are dropped.
            if (B0 && !owner[0]) begin
                pend0 <= 1'b1;
            end
            if (B1 && !owner[1]) begin
                pend1 <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/laser_burst_ctrl.sv
// ---------------------------------------------------------------------------
// laser_burst_ctrl
// Shares one laser drive between two requesters and turns each grant into a
// burst of PULSES ON phases separated by OFF gaps, followed by a cooldown.
// Build option: LASER_ROUND_ROBIN_EN (round-robin arbitration, see
// laser_req_arbiter); undefined gives fixed priority to requester 0.
// Parameters: ON_LEN, OFF_LEN, PULSES, COOLDOWN (all >= 1)
// Ports:
//   CLK    : clock, rising edge
//   Reset  : synchronous active-high reset
//   B0, B1 : requesters 0 and 1
//   XL     : laser drive
//   Grant  : one-hot owner of the current burst, 00 when idle
//   Busy   : high from burst start through the last cooldown cycle
//   Done   : one-cycle pulse in the first cooldown cycle
// ---------------------------------------------------------------------------
module laser_burst_ctrl
    import laser_pkg::*;
#(
    parameter int ON_LEN   = LASER_ON_LEN,
    parameter int OFF_LEN  = LASER_OFF_LEN,
    parameter int PULSES   = LASER_PULSES,
    parameter int COOLDOWN = LASER_COOLDOWN
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       B0,
    input  logic       B1,
    output logic       XL,
    output logic [1:0] Grant,
    output logic       Busy,
    output logic       Done
);

    localparam int PH_W = $clog2(laser_max3(ON_LEN, OFF_LEN, COOLDOWN) + 1);
    localparam int PC_W = $clog2(PULSES + 1);

    localparam logic [PH_W-1:0] ON_LAST    = PH_W'(ON_LEN - 1);
    localparam logic [PH_W-1:0] OFF_LAST   = PH_W'(OFF_LEN - 1);
    localparam logic [PH_W-1:0] COOL_LAST  = PH_W'(COOLDOWN - 1);
    localparam logic [PC_W-1:0] PULSE_LAST = PC_W'(PULSES - 1);

    laser_state_t    state;
    laser_state_t    state_next;
    logic [PH_W-1:0] phase_cnt;
    logic [PC_W-1:0] pulse_cnt;
    logic            phase_done;
    logic            last_pulse;
    logic            arb_en;
    logic            grant_valid;
    logic [1:0]      winner;

    // Phase counter starts at 0 on entry, so a phase ends when it reaches
    // LEN-1 and lasts exactly LEN cycles.
    always_comb begin
        phase_done = 1'b0;
        case (state)
            ON:      phase_done = (phase_cnt == ON_LAST);
            OFF:     phase_done = (phase_cnt == OFF_LAST);
            COOL:    phase_done = (phase_cnt == COOL_LAST);
            default: phase_done = 1'b0;
        endcase
    end

    assign last_pulse = (pulse_cnt == PULSE_LAST);

    // The last cooldown edge behaves like IDLE so a pending request starts
    // on the edge where Busy would otherwise fall, with no idle gap.
    assign arb_en = (state == IDLE) || ((state == COOL) && phase_done);

    laser_req_arbiter u_arb (
        .CLK         (CLK),
        .Reset       (Reset),
        .B0          (B0),
        .B1          (B1),
        .arb_en      (arb_en),
        .owner       (Grant),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ON;
                end
            end
            ON: begin
                if (phase_done) begin
                    state_next = last_pulse ? COOL : OFF;
                end
            end
            OFF: begin
                if (phase_done) begin
                    state_next = ON;
                end
            end
            COOL: begin
                if (phase_done) begin
                    state_next = grant_valid ? ON : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            phase_cnt <= '0;
            pulse_cnt <= '0;
        end else begin
            if (state_next != state) begin
                phase_cnt <= '0;
            end else if (state != IDLE) begin
                phase_cnt <= phase_cnt + 1'b1;
            end

            // Counts completed ON phases; the last one returns it to 0 as
            // the burst enters cooldown.
            if ((state == ON) && phase_done) begin
                pulse_cnt <= last_pulse ? '0 : pulse_cnt + 1'b1;
            end
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state they describe.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            XL    <= 1'b0;
            Grant <= 2'b00;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            XL   <= (state_next == ON);
            Busy <= (state_next != IDLE);
            Done <= (state == ON) && (state_next == COOL);
            if (grant_valid) begin
                Grant <= winner;
            end else if (state_next == IDLE) begin
                Grant <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_laser_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_laser_burst_ctrl
// Directed bench for laser_burst_ctrl. The main instance uses default
// parameters; a second instance uses PULSES=1, COOLDOWN=1 for the held-button
// repeat scenario. Observed outputs are packed as {XL, Busy, Grant, Done}.
// ---------------------------------------------------------------------------
module tb_laser_burst_ctrl;

    logic       CLK   = 1'b0;
    logic       Reset = 1'b1;
    logic       B0    = 1'b0;
    logic       B1    = 1'b0;
    logic       XL;
    logic [1:0] Grant;
    logic       Busy;
    logic       Done;

    logic       b0_s = 1'b0;
    logic       b1_s = 1'b0;
    logic       xl_s;
    logic [1:0] grant_s;
    logic       busy_s;
    logic       done_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    laser_burst_ctrl dut (
        .CLK   (CLK),
        .Reset (Reset),
        .B0    (B0),
        .B1    (B1),
        .XL    (XL),
        .Grant (Grant),
        .Busy  (Busy),
        .Done  (Done)
    );

    laser_burst_ctrl #(
        .ON_LEN   (16),
        .OFF_LEN  (8),
        .PULSES   (1),
        .COOLDOWN (1)
    ) dut_s (
        .CLK   (CLK),
        .Reset (Reset),
        .B0    (b0_s),
        .B1    (b1_s),
        .XL    (xl_s),
        .Grant (grant_s),
        .Busy  (busy_s),
        .Done  (done_s)
    );

    // Sample point: 1 ns after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Default burst: ON 0-15, OFF 16-23, ON 24-39, OFF 40-47, ON 48-63.
    function automatic logic burst_xl(input int c);
        return (c >= 0) && (c < 64) && ((c % 24) < 16);
    endfunction

    task automatic test_reset();
        logic [4:0] obs;
        #44;
        obs = {XL, Busy, Grant, Done};
        n_cmp++;
        if (obs !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_held got %b want %b", obs, 5'b0);
        end
        #6;
        Reset = 1'b0;
        tick();
        obs = {XL, Busy, Grant, Done};
        n_cmp++;
        if (obs !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_released got %b want %b", obs, 5'b0);
        end
    endtask

    task automatic test_single_burst();
        logic [4:0] obs;
        logic [4:0] exp;
        B0 = 1'b1;
        tick();
        B0 = 1'b0;
        for (int c = 0; c < 100; c++) begin
            exp = {burst_xl(c), (c < 96), (c < 96) ? 2'b01 : 2'b00, (c == 64)};
            obs = {XL, Busy, Grant, Done};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL single_burst c=%0d got %b want %b", c, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] obs;
        logic [4:0] exp;
        logic [1:0] g;
        B0 = 1'b1;
        B1 = 1'b1;
        tick();
        B0 = 1'b0;
        B1 = 1'b0;
        for (int c = 0; c < 200; c++) begin
            g   = (c < 96) ? 2'b01 : (c < 192) ? 2'b10 : 2'b00;
            exp = {(c < 192) && burst_xl(c % 96), (c < 192), g, (c == 64) || (c == 160)};
            obs = {XL, Busy, Grant, Done};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL back_to_back c=%0d got %b want %b", c, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_drop_and_pending();
        logic [4:0] obs;
        logic [4:0] exp;
        logic [1:0] g;
        B1 = 1'b1;
        tick();
        B1 = 1'b0;
        for (int c = 0; c < 300; c++) begin
            g   = (c < 96) ? 2'b10 : (c < 192) ? 2'b01 : 2'b00;
            exp = {(c < 192) && burst_xl(c % 96), (c < 192), g, (c == 64) || (c == 160)};
            obs = {XL, Busy, Grant, Done};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL drop_pending c=%0d got %b want %b", c, obs, exp);
            end
            B1 = (c == 10);
            B0 = (c == 20);
            tick();
        end
        B0 = 1'b0;
        B1 = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [4:0] obs;
        B0 = 1'b1;
        tick();
        B0 = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            obs = {XL, Busy, Grant, Done};
            n_cmp++;
            if (obs !== 5'b11010) begin
                n_bad++;
                $display("FAIL mid_burst_on c=%0d got %b want %b", c, obs, 5'b11010);
            end
            B1 = (c == 1);
            tick();
        end
        // Now in ON cycle 6 with pend1 set; reset wins over a same-cycle B0.
        Reset = 1'b1;
        B0    = 1'b1;
        tick();
        obs = {XL, Busy, Grant, Done};
        n_cmp++;
        if (obs !== 5'b0) begin
            n_bad++;
            $display("FAIL mid_burst_reset got %b want %b", obs, 5'b0);
        end
        Reset = 1'b0;
        B0    = 1'b0;
        for (int c = 0; c < 150; c++) begin
            tick();
            obs = {XL, Busy, Grant, Done};
            n_cmp++;
            if (obs !== 5'b0) begin
                n_bad++;
                $display("FAIL post_reset_idle c=%0d got %b want %b", c, obs, 5'b0);
                break;
            end
        end
    endtask

    // Two rounds of simultaneous requests; records owner at each burst start.
    task automatic test_second_round();
        logic [1:0] exp_order [4];
        logic [1:0] got;
        int         k;
        exp_order[0] = 2'b01;
        exp_order[1] = 2'b10;
`ifdef LASER_ROUND_ROBIN_EN
        exp_order[2] = 2'b10;
        exp_order[3] = 2'b01;
`else
        exp_order[2] = 2'b01;
        exp_order[3] = 2'b10;
`endif
        k = 0;
        for (int r = 0; r < 2; r++) begin
            B0 = 1'b1;
            B1 = 1'b1;
            tick();
            B0 = 1'b0;
            B1 = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (c == 0 || c == 96) begin
                    got = Grant;
                    n_cmp++;
                    if (got !== exp_order[k]) begin
                        n_bad++;
                        $display("FAIL round_order burst=%0d got %b want %b", k, got, exp_order[k]);
                    end
                    k++;
                end
                tick();
            end
        end
    endtask

    task automatic test_held_repeat();
        logic [4:0] obs;
        logic [4:0] exp;
        b0_s = 1'b1;
        tick();
        for (int c = 0; c <= 50; c++) begin
            exp = {((c % 17) < 16), 1'b1, 2'b01, ((c % 17) == 16)};
            obs = {xl_s, busy_s, grant_s, done_s};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL held_repeat c=%0d got %b want %b", c, obs, exp);
            end
            tick();
        end
        b0_s = 1'b0;
        repeat (40) tick();
        obs = {xl_s, busy_s, grant_s, done_s};
        n_cmp++;
        if (obs !== 5'b0) begin
            n_bad++;
            $display("FAIL held_release got %b want %b", obs, 5'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_drop_and_pending();
        test_reset_mid_burst();
        test_second_round();
        test_held_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
